irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Interrupt controller that collects IRQ lines from the timer and other peripherals and arbitrates them onto one CPU interrupt request.
- Latches rising edges into a pending register, masks them with an enable register, and selects the lowest-index source.
- Runs a request/acknowledge/end-of-interrupt sequence with the CPU.
- Sits on the same device bus as the timer and exposes a 4-word register file (we/addr/din/dout).

Parameters:
- N_SRC, 6, number of interrupt sources; legal range 1..8.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- irq_src  in  N_SRC  level IRQ lines from devices, synchronous to clk
- we  in  1  bus write enable
- addr  in  2  register select
- din  in  32  bus write data
- dout  out  32  bus read data, combinational from addr
- int_req  out  1  registered interrupt request to CPU
- int_id  out  3  ID of requested/in-service source
- int_ack  in  1  CPU acknowledge, single-cycle pulse

Behaviour:
- Reset (rst low, asynchronous):
  - ENABLE=0, PENDING=0, prev_src=0, state IDLE.
  - int_req=0, int_id=0, in-service id=0.
- Edge detect: on each edge, PENDING[i] is set if irq_src[i]=1 and prev_src[i]=0; prev_src<=irq_src.
  - A source held high through reset release therefore sets PENDING on the first edge; ENABLE=0 keeps it harmless.
- Register map (dout zero-extended; bits above N_SRC read 0):
  - addr 0 ENABLE: read/write bits[N_SRC-1:0].
  - addr 1 PENDING: read; a write of 1 clears the corresponding bit (W1C), a write of 0 has no effect.
  - addr 2 STATUS: read {busy at bit31, int_req at bit30, int_id at bits 2:0}; busy = state SERVICE. Any write is an EOI.
  - addr 3 RAW: read irq_src; writes ignored.
- Set/clear priority: an edge-set and a W1C/EOI-clear of the same bit in the same cycle leave the bit set (set wins).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if (PENDING & ENABLE) != 0, latch the lowest set index into int_id and go to REQ.
  - REQ: int_req=1 (registered, equals state==REQ).
    - int_ack=1 -> SERVICE. The in-service id is int_id.
    - Else, if PENDING[int_id]&ENABLE[int_id]=0 (cleared or masked) -> IDLE, request withdrawn.
    - int_ack has priority over withdrawal in the same cycle.
  - SERVICE: int_req=0, int_id holds.
    - EOI write -> clear PENDING[int_id] (subject to set-wins) and go to IDLE.
    - int_ack is ignored in IDLE and SERVICE.
- No preemption: int_id is frozen from REQ entry until the return to IDLE, even if a higher-priority source arrives.
- Latency: irq_src first sampled high at edge k -> PENDING set after k -> REQ/int_req=1 after edge k+1 (2 clocks).
  - After EOI at edge m, the next request can assert after edge m+1.
- Writes to ENABLE/PENDING take effect for the FSM decision on the following edge.
- Reset mid-operation: asynchronous return to the reset values above from any state; no residual request.

Test Plan:
- Reset release with irq_src=6'b000001, ENABLE=0 -> PENDING reads 0x1, int_req stays 0 for 10 cycles. Then W1C 0x1 to addr 1 -> PENDING reads 0.
- ENABLE=0x3F; pulse irq_src[2] at edge k -> int_req=1, int_id=2 after edge k+1. Pulse int_ack -> STATUS=0x80000002, int_req=0. Write addr 2 -> PENDING=0, STATUS=0, state IDLE.
- Sources 4 and 1 rising on the same edge -> int_id=1 first. After ack+EOI, int_id=4 follows 2 cycles after EOI.
- In REQ for id 3, source 0 rises -> int_id stays 3 until EOI, then id 0 is served.
- In REQ for id 5, write ENABLE=0 (without ack) -> int_req drops the following cycle and PENDING[5] stays set. Re-enable -> the request reasserts.
- In SERVICE id 2, EOI write coincides with a new rising edge on irq_src[2] -> PENDING[2] remains 1 and a new request for id 2 follows. Assert rst low mid-REQ -> int_req=0 immediately and all registers read 0.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-latched, maskable interrupt arbiter with a
// request/acknowledge/EOI handshake and a 4-word bus register file.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   irq_src  level IRQ lines from devices (synchronous to clk)
//   we       bus write enable
//   addr     register select: 0 ENABLE, 1 PENDING, 2 STATUS, 3 RAW
//   din      bus write data
//   dout     bus read data, combinational from addr
//   int_req  registered interrupt request to the CPU
//   int_id   id of the requested / in-service source
//   int_ack  CPU acknowledge, single-cycle pulse
module irq_arbiter #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic             int_req,
    output logic [2:0]       int_id,
    input  logic             int_ack
);

    localparam logic [1:0] A_ENABLE  = 2'd0;
    localparam logic [1:0] A_PENDING = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_RAW     = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N_SRC-1:0] enable_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] w1c_clr;
    logic [N_SRC-1:0] eoi_clr;
    logic [N_SRC-1:0] active;

    logic [2:0] id_q, id_d;
    logic [2:0] low_id;
    logic       low_vld;
    logic       cur_active;
    logic       req_q;

    logic wr_enable;
    logic wr_pending;
    logic wr_eoi;
    logic eoi_fire;

    logic unused_din;
    assign unused_din = ^din[31:N_SRC];

    // Bus write decode
    assign wr_enable  = we && (addr == A_ENABLE);
    assign wr_pending = we && (addr == A_PENDING);
    assign wr_eoi     = we && (addr == A_STATUS);
    assign eoi_fire   = wr_eoi && (state_q == SERVICE);

    // Rising-edge detect and masking
    assign edge_set = irq_src & ~prev_q;
    assign active   = pending_q & enable_q;
    assign w1c_clr  = wr_pending ? din[N_SRC-1:0] : '0;

    // Lowest-index active source; descending scan so the
    // last assignment wins with the smallest index.
    always_comb begin
        low_id  = '0;
        low_vld = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                low_id  = 3'(i);
                low_vld = 1'b1;
            end
        end
    end

    // Select by id without indexing past N_SRC
    always_comb begin
        cur_active = 1'b0;
        eoi_clr    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (id_q == 3'(i)) begin
                cur_active = active[i];
                eoi_clr[i] = eoi_fire;
            end
        end
    end

    // An edge in the same cycle as a clear keeps the bit set
    assign pending_d = (pending_q & ~(w1c_clr | eoi_clr)) | edge_set;

    // Bus-visible registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q  <= '0;
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            prev_q    <= irq_src;
            pending_q <= pending_d;
            if (wr_enable) begin
                enable_q <= din[N_SRC-1:0];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= (state_d == REQ);
        end
    end

    // FSM: next state. id is frozen from REQ entry until
    // the return to IDLE, where it is cleared.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (low_vld) begin
                    state_d = REQ;
                    id_d    = low_id;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d = SERVICE;
                end else if (!cur_active) begin
                    state_d = IDLE;
                    id_d    = '0;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_d = IDLE;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
            end
        endcase
    end

    // FSM: outputs and read mux
    always_comb begin
        int_req = req_q;
        int_id  = id_q;
        dout    = '0;
        unique case (addr)
            A_ENABLE:  dout[N_SRC-1:0] = enable_q;
            A_PENDING: dout[N_SRC-1:0] = pending_q;
            A_STATUS: begin
                dout[31]  = (state_q == SERVICE);
                dout[30]  = req_q;
                dout[2:0] = id_q;
            end
            A_RAW:     dout[N_SRC-1:0] = irq_src;
            default:   dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus random traffic,
// checked against a behavioural model of the arbiter.
module tb_irq_arbiter;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic          we = 1'b0;
    logic [1:0]    addr = '0;
    logic [31:0]   din = '0;
    logic [31:0]   dout;
    logic          int_req;
    logic [2:0]    int_id;
    logic          int_ack = 1'b0;

    int total = 0;
    int bad = 0;

    irq_arbiter #(.N_SRC(N)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .we(we), .addr(addr), .din(din), .dout(dout),
        .int_req(int_req), .int_id(int_id), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    // Model: "waiting" = request raised, "serving" = acked
    bit           m_wait, m_serv;
    int           m_id;
    bit [N-1:0]   m_pend, m_en, m_prev;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic int lowest(bit [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] mread(logic [1:0] a);
        logic [31:0] r = '0;
        case (a)
            2'd0: r[N-1:0] = m_en;
            2'd1: r[N-1:0] = m_pend;
            2'd2: r = {m_serv, m_wait, 27'd0, 3'(m_id)};
            default: r[N-1:0] = irq_src;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_serv = 0; m_id = 0;
        m_pend = '0; m_en = '0; m_prev = '0;
    endtask

    // One clock: predict from the inputs now driven, then compare.
    task automatic cyc();
        bit [N-1:0] clr, nxt_pend, nxt_en;
        bit         nw, ns;
        int         nid;
        clr = '0; nw = m_wait; ns = m_serv; nid = m_id;
        if (we && addr == 2'd1) clr = din[N-1:0];
        if (!m_wait && !m_serv) begin
            if ((m_pend & m_en) != 0) begin
                nw = 1; nid = lowest(m_pend & m_en);
            end
        end else if (m_wait) begin
            if (int_ack) begin
                nw = 0; ns = 1;
            end else if (!(m_pend[m_id] && m_en[m_id])) begin
                nw = 0; nid = 0;
            end
        end else if (we && addr == 2'd2) begin
            clr[m_id] = 1'b1; ns = 0; nid = 0;
        end
        nxt_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
        nxt_en = (we && addr == 2'd0) ? din[N-1:0] : m_en;
        m_prev = irq_src;
        @(posedge clk);
        m_pend = nxt_pend; m_en = nxt_en;
        m_wait = nw; m_serv = ns; m_id = nid;
        #1;
        check("int_req", 32'(int_req), 32'(m_wait));
        check("int_id", 32'(int_id), 32'(m_id));
        check("dout", dout, mread(addr));
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        we = 1'b1; addr = a; din = d;
        cyc();
        we = 1'b0; din = '0;
    endtask

    task automatic peek(logic [1:0] a, string tag);
        addr = a;
        #1;
        check(tag, dout, mread(a));
    endtask

    task automatic pulse(logic [N-1:0] v);
        irq_src = v; cyc();
        irq_src = '0;
    endtask

    task automatic ack_eoi();
        int_ack = 1'b1; cyc();
        int_ack = 1'b0;
        wr(2'd2, 32'd0);
    endtask

    initial begin
        model_reset();
        // Source 0 held high through reset release
        irq_src = 6'b000001;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        addr = 2'd1;
        for (int i = 0; i < 10; i++) cyc();
        check("held_pend", dout, 32'h1);
        check("held_noreq", 32'(int_req), 32'h0);
        wr(2'd1, 32'h1);
        peek(2'd1, "w1c_pend");
        check("w1c_zero", dout, 32'h0);
        irq_src = '0; cyc();

        // Single source, ack, EOI
        wr(2'd0, 32'h3F);
        pulse(6'b000100);
        cyc();
        check("req_id2", {int_req, int_id}, {1'b1, 3'd2});
        int_ack = 1'b1; addr = 2'd2; cyc();
        int_ack = 1'b0;
        check("stat_serv", dout, 32'h80000002);
        wr(2'd2, 32'd0);
        check("stat_eoi", dout, 32'h0);
        peek(2'd1, "pend_eoi");

        // Simultaneous sources 4 and 1
        pulse(6'b010010);
        cyc();
        check("pri_id1", 32'(int_id), 32'd1);
        ack_eoi();
        cyc();
        check("next_id4", {int_req, int_id}, {1'b1, 3'd4});
        ack_eoi();

        // No preemption
        pulse(6'b001000);
        cyc();
        pulse(6'b000001);
        cyc();
        check("nopre_id3", {int_req, int_id}, {1'b1, 3'd3});
        ack_eoi();
        cyc();
        check("then_id0", {int_req, int_id}, {1'b1, 3'd0});
        ack_eoi();

        // Withdrawal by masking, then re-enable
        pulse(6'b100000);
        cyc();
        wr(2'd0, 32'h0);
        cyc();
        check("withdrawn", 32'(int_req), 32'h0);
        peek(2'd1, "pend_kept");
        check("pend5", dout, 32'h20);
        wr(2'd0, 32'h3F);
        cyc();
        check("reassert", {int_req, int_id}, {1'b1, 3'd5});
        ack_eoi();

        // EOI coinciding with a new edge on the same source
        pulse(6'b000100);
        cyc();
        int_ack = 1'b1; cyc();
        int_ack = 1'b0;
        irq_src = 6'b000100;
        wr(2'd2, 32'd0);
        irq_src = '0;
        peek(2'd1, "setwins");
        check("setwins_v", dout, 32'h4);
        cyc();
        check("again_id2", {int_req, int_id}, {1'b1, 3'd2});

        // Asynchronous reset while requesting
        #2 rst = 1'b0;
        #1 check("rst_req", 32'(int_req), 32'h0);
        model_reset();
        for (int a = 0; a < 4; a++) peek(2'(a), "rst_reg");
        @(posedge clk);
        #1 rst = 1'b1;

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) irq_src[b] = ~irq_src[b];
            we = ($urandom_range(5) == 0);
            addr = 2'($urandom_range(3));
            din = $urandom;
            if (addr == 2'd0 && $urandom_range(2) != 0) din[5:0] = 6'h3F;
            if (m_wait) int_ack = ($urandom_range(2) == 0);
            else int_ack = ($urandom_range(9) == 0);
            cyc();
        end
        we = 1'b0; int_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
